// File: rtl/reg_guard_pkg.sv
// Shared types for the register access guard: privilege encoding,
// error codes, policy-table entry layout and guard FSM states.
package reg_guard_pkg;

   typedef enum logic [1:0] {
      PRIV_U    = 2'b00,
      PRIV_S    = 2'b01,
      PRIV_RSVD = 2'b10,
      PRIV_M    = 2'b11
   } priv_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_PRIV      = 2'd1,
      ERR_UNMAPPED  = 2'd2,
      ERR_RSVD_PRIV = 2'd3
   } guard_err_e;

   typedef struct packed {
      priv_e min_priv;
      logic  lock;
   } policy_entry_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } guard_state_e;

   // Every entry comes out of reset as "machine mode only", unlocked.
   localparam policy_entry_t POLICY_RESET = '{min_priv: PRIV_M, lock: 1'b0};

   // Index width for a table of n entries; a single-entry table still needs one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_guard_policy_tbl.sv
// Per-register minimum-privilege table with sticky lock bits.
// A config write lands only from machine mode, on an unlocked, in-range
// entry; anything else leaves the table alone and pulses cfg_err_o.
module reg_guard_policy_tbl
   import reg_guard_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned IDX_W    = idx_width(NUM_REGS)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             cfg_we_i,
   input  logic [IDX_W-1:0] cfg_idx_i,
   input  logic [1:0]       cfg_min_priv_i,
   input  logic             cfg_lock_i,
   input  logic [1:0]       cfg_priv_i,
   output logic             cfg_err_o,
   input  logic [IDX_W-1:0] lk_idx_i,
   output priv_e            lk_min_priv_o
);

   policy_entry_t tbl_q [NUM_REGS];
   policy_entry_t tbl_d [NUM_REGS];
   logic          cfg_err_q;
   logic          cfg_err_d;
   logic          cfg_idx_ok;
   logic          lk_idx_ok;
   logic          cfg_accept;

   assign cfg_idx_ok = ({1'b0, cfg_idx_i} < (IDX_W + 1)'(NUM_REGS));
   assign lk_idx_ok  = ({1'b0, lk_idx_i} < (IDX_W + 1)'(NUM_REGS));

   // Decide whether the config write may land, and build the next table.
   always_comb begin
      cfg_accept = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         tbl_d[i] = tbl_q[i];
      end
      if (cfg_we_i && (cfg_priv_i == PRIV_M) && cfg_idx_ok) begin
         cfg_accept = !tbl_q[cfg_idx_i].lock;
      end
      if (cfg_accept) begin
         tbl_d[cfg_idx_i].min_priv = priv_e'(cfg_min_priv_i);
         tbl_d[cfg_idx_i].lock     = cfg_lock_i;
      end
      cfg_err_d = cfg_we_i && !cfg_accept;
   end

   // Table and rejection-pulse registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            tbl_q[i] <= POLICY_RESET;
         end
         cfg_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            tbl_q[i] <= tbl_d[i];
         end
         cfg_err_q <= cfg_err_d;
      end
   end

   // Lookup reads the registered table only, so a write in the same
   // cycle as a check is not seen by that check.
   always_comb begin
      lk_min_priv_o = PRIV_M;
      if (lk_idx_ok) begin
         lk_min_priv_o = tbl_q[lk_idx_i].min_priv;
      end
   end

   assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/reg_access_guard.sv
// Access-control gate between the CPU load/store path and a block of
// privileged CSR-style registers. Holds the request FSM, the saturating
// violation counter and (with REG_ACCESS_GUARD_AUDIT_EN defined) a
// sticky capture of the first denied request.
//
// Handshake: a request transfers on a cycle where req_valid_i and
// req_ready_o are both high; a response transfers on a cycle where
// rsp_valid_o and rsp_ready_i are both high. rsp_* outputs hold stable
// while rsp_valid_o is high and rsp_ready_i is low.
module reg_access_guard
   import reg_guard_pkg::*;
#(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned NUM_REGS = 8,
   parameter logic [ADDR_W-1:0] REG_BASE = ADDR_W'('h060),
   parameter int unsigned CNT_W    = 8,
   localparam int unsigned IDX_W   = idx_width(NUM_REGS)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [1:0]        req_priv_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_grant_o,
   output logic              rsp_exc_o,
   output logic [1:0]        rsp_err_o,
   input  logic              cfg_we_i,
   input  logic [IDX_W-1:0]  cfg_idx_i,
   input  logic [1:0]        cfg_min_priv_i,
   input  logic              cfg_lock_i,
   input  logic [1:0]        cfg_priv_i,
   output logic              cfg_err_o,
   output logic [CNT_W-1:0]  viol_cnt_o,
   input  logic              viol_clr_i
`ifdef REG_ACCESS_GUARD_AUDIT_EN
   ,
   output logic              fault_valid_o,
   output logic [ADDR_W-1:0] fault_addr_o,
   output logic [1:0]        fault_priv_o,
   output logic              fault_write_o,
   input  logic              fault_clr_i
`endif
);

   guard_state_e      state_q, state_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        priv_q, priv_d;
   guard_err_e        err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cnt_inc;

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] reg_idx;
   logic              unmapped;
   priv_e             lk_min_priv;
   guard_err_e        chk_err;

   reg_guard_policy_tbl #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_policy_tbl (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cfg_we_i       (cfg_we_i),
      .cfg_idx_i      (cfg_idx_i),
      .cfg_min_priv_i (cfg_min_priv_i),
      .cfg_lock_i     (cfg_lock_i),
      .cfg_priv_i     (cfg_priv_i),
      .cfg_err_o      (cfg_err_o),
      .lk_idx_i       (reg_idx[IDX_W-1:0]),
      .lk_min_priv_o  (lk_min_priv)
   );

   // Decode the latched request and evaluate it, first matching rule wins.
   always_comb begin
      offset   = addr_q - REG_BASE;
      reg_idx  = offset >> 2;
      unmapped = (addr_q < REG_BASE) || (addr_q[1:0] != 2'b00) ||
                 (reg_idx >= ADDR_W'(NUM_REGS));
      chk_err  = ERR_NONE;
      if (priv_q == PRIV_RSVD) begin
         chk_err = ERR_RSVD_PRIV;
      end else if (unmapped) begin
         chk_err = ERR_UNMAPPED;
      end else if (priv_q < lk_min_priv) begin
         chk_err = ERR_PRIV;
      end
   end

   // Request FSM next-state: accept in IDLE, judge in CHECK, hold in RESP.
   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      priv_d  = priv_q;
      err_d   = err_q;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               addr_d  = req_addr_i;
               priv_d  = req_priv_i;
               state_d = CHECK;
            end
         end
         CHECK: begin
            err_d   = chk_err;
            cnt_inc = (chk_err != ERR_NONE);
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Violation counter next value; a clear coinciding with a deny leaves one.
   always_comb begin
      cnt_d = cnt_q;
      if (viol_clr_i) begin
         cnt_d = cnt_inc ? CNT_W'(1) : '0;
      end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // FSM, latched request, result and counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         priv_q  <= '0;
         err_q   <= ERR_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         priv_q  <= priv_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready_o = rst_ni && (state_q == IDLE);
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_grant_o = rsp_valid_o && (err_q == ERR_NONE);
   assign rsp_exc_o   = rsp_valid_o && (err_q != ERR_NONE);
   assign rsp_err_o   = rsp_valid_o ? err_q : ERR_NONE;
   assign viol_cnt_o  = cnt_q;

`ifdef REG_ACCESS_GUARD_AUDIT_EN
   logic              fault_valid_q, fault_valid_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
   logic [1:0]        fault_priv_q, fault_priv_d;
   logic              fault_write_q, fault_write_d;

   // Capture the first deny while empty; a clear beats a same-cycle capture.
   always_comb begin
      fault_valid_d = fault_valid_q;
      fault_addr_d  = fault_addr_q;
      fault_priv_d  = fault_priv_q;
      fault_write_d = fault_write_q;
      if (fault_clr_i) begin
         fault_valid_d = 1'b0;
         fault_addr_d  = '0;
         fault_priv_d  = '0;
         fault_write_d = 1'b0;
      end else if (cnt_inc && !fault_valid_q) begin
         fault_valid_d = 1'b1;
         fault_addr_d  = addr_q;
         fault_priv_d  = priv_q;
         fault_write_d = write_q;
      end
   end

   // Audit capture registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         fault_valid_q <= 1'b0;
         fault_addr_q  <= '0;
         fault_priv_q  <= '0;
         fault_write_q <= 1'b0;
      end else begin
         fault_valid_q <= fault_valid_d;
         fault_addr_q  <= fault_addr_d;
         fault_priv_q  <= fault_priv_d;
         fault_write_q <= fault_write_d;
      end
   end

   assign fault_valid_o = fault_valid_q;
   assign fault_addr_o  = fault_addr_q;
   assign fault_priv_o  = fault_priv_q;
   assign fault_write_o = fault_write_q;
`else
   // The write direction only feeds the audit capture.
   logic unused_write;
   assign unused_write = write_q;
`endif

endmodule

// File: tb/tb_reg_access_guard.sv
// Directed bench for reg_access_guard (NUM_REGS=8, REG_BASE=12'h060, CNT_W=2
// so counter saturation is reachable). Audit checks compile in when
// REG_ACCESS_GUARD_AUDIT_EN is defined.
module tb_reg_access_guard;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready_o;
   logic        req_write = 1'b0;
   logic [11:0] req_addr = '0;
   logic [1:0]  req_priv = '0;
   logic        rsp_valid_o;
   logic        rsp_ready = 1'b1;
   logic        rsp_grant_o;
   logic        rsp_exc_o;
   logic [1:0]  rsp_err_o;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_idx = '0;
   logic [1:0]  cfg_min_priv = '0;
   logic        cfg_lock = 1'b0;
   logic [1:0]  cfg_priv = '0;
   logic        cfg_err_o;
   logic [1:0]  viol_cnt_o;
   logic        viol_clr = 1'b0;
`ifdef REG_ACCESS_GUARD_AUDIT_EN
   logic        fault_valid_o;
   logic [11:0] fault_addr_o;
   logic [1:0]  fault_priv_o;
   logic        fault_write_o;
   logic        fault_clr = 1'b0;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   logic [1:0]  exp_cnt = '0;

   localparam logic [1:0] U = 2'b00, S = 2'b01, R = 2'b10, M = 2'b11;
   localparam logic [1:0] E_NONE = 2'd0, E_PRIV = 2'd1, E_UNMAP = 2'd2, E_RSVD = 2'd3;

   reg_access_guard #(
      .ADDR_W   (12),
      .NUM_REGS (8),
      .REG_BASE (12'h060),
      .CNT_W    (2)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready_o),
      .req_write_i    (req_write),
      .req_addr_i     (req_addr),
      .req_priv_i     (req_priv),
      .rsp_valid_o    (rsp_valid_o),
      .rsp_ready_i    (rsp_ready),
      .rsp_grant_o    (rsp_grant_o),
      .rsp_exc_o      (rsp_exc_o),
      .rsp_err_o      (rsp_err_o),
      .cfg_we_i       (cfg_we),
      .cfg_idx_i      (cfg_idx),
      .cfg_min_priv_i (cfg_min_priv),
      .cfg_lock_i     (cfg_lock),
      .cfg_priv_i     (cfg_priv),
      .cfg_err_o      (cfg_err_o),
      .viol_cnt_o     (viol_cnt_o),
      .viol_clr_i     (viol_clr)
`ifdef REG_ACCESS_GUARD_AUDIT_EN
      ,
      .fault_valid_o  (fault_valid_o),
      .fault_addr_o   (fault_addr_o),
      .fault_priv_o   (fault_priv_o),
      .fault_write_o  (fault_write_o),
      .fault_clr_i    (fault_clr)
`endif
   );

   // Clock.
   always #5 clk_i = ~clk_i;

   // Scoreboard check: one comparison, one line on a miscompare.
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // One request; mid=1 pulses viol_clr during CHECK, mid=2 fires the
   // preset config write during CHECK. Bench is positioned at a negedge.
   task automatic issue(input string tag, input logic wr, input logic [11:0] addr,
                        input logic [1:0] priv, input int mid, input logic [1:0] exp_err);
      int t;
      t = 0;
      while (!req_ready_o && t < 8) begin
         @(negedge clk_i);
         t++;
      end
      check({tag, "_rdy"}, req_ready_o, 1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_priv  = priv;
      @(negedge clk_i);
      req_valid = 1'b0;
      if (mid == 1) viol_clr = 1'b1;
      if (mid == 2) cfg_we = 1'b1;
      @(negedge clk_i);
      viol_clr = 1'b0;
      cfg_we   = 1'b0;
      if (exp_err != E_NONE) exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
      if (mid == 1) exp_cnt = (exp_err != E_NONE) ? 2'd1 : 2'd0;
      t = 0;
      while (!rsp_valid_o && t < 4) begin
         @(negedge clk_i);
         t++;
      end
      check({tag, "_vld"}, rsp_valid_o, 1);
      check({tag, "_gnt"}, rsp_grant_o, exp_err == E_NONE);
      check({tag, "_exc"}, rsp_exc_o, exp_err != E_NONE);
      check({tag, "_err"}, rsp_err_o, exp_err);
      check({tag, "_cnt"}, viol_cnt_o, exp_cnt);
      @(negedge clk_i);
   endtask

   // One config write; checks the rejection pulse and that it drops again.
   task automatic cfg_write(input string tag, input logic [2:0] idx, input logic [1:0] minp,
                            input logic lk, input logic [1:0] priv, input logic exp_err);
      cfg_idx      = idx;
      cfg_min_priv = minp;
      cfg_lock     = lk;
      cfg_priv     = priv;
      cfg_we       = 1'b1;
      @(negedge clk_i);
      cfg_we = 1'b0;
      check({tag, "_cerr"}, cfg_err_o, exp_err);
      @(negedge clk_i);
      check({tag, "_cerr_end"}, cfg_err_o, 0);
   endtask

   task automatic clear_cnt(input string tag);
      viol_clr = 1'b1;
      @(negedge clk_i);
      viol_clr = 1'b0;
      exp_cnt = '0;
      check({tag, "_clr"}, viol_cnt_o, 0);
   endtask

   initial begin
      // Reset state, observed while rst_ni is still low.
      repeat (2) @(negedge clk_i);
      check("rst_ready", req_ready_o, 0);
      check("rst_valid", rsp_valid_o, 0);
      check("rst_grant", rsp_grant_o, 0);
      check("rst_exc",   rsp_exc_o, 0);
      check("rst_err",   rsp_err_o, E_NONE);
      check("rst_cnt",   viol_cnt_o, 0);
      check("rst_cerr",  cfg_err_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Default policy is M for every entry.
      issue("u_rd_064", 1'b0, 12'h064, U, 0, E_PRIV);
      issue("m_rd_064", 1'b0, 12'h064, M, 0, E_NONE);

      // Lower entry 1 to S, then try to change it from S mode.
      cfg_write("cfg1_s", 3'd1, S, 1'b0, M, 1'b0);
      issue("u_wr_064", 1'b1, 12'h064, U, 0, E_PRIV);
      issue("s_wr_064", 1'b1, 12'h064, S, 0, E_NONE);
      cfg_write("cfg1_by_s", 3'd1, U, 1'b0, S, 1'b1);
      issue("u_rd_064b", 1'b0, 12'h064, U, 0, E_PRIV);
      issue("s_rd_064", 1'b0, 12'h064, S, 0, E_NONE);

      // Lock entry 2 at M; a later downgrade is refused.
      cfg_write("lock2", 3'd2, M, 1'b1, M, 1'b0);
      cfg_write("lock2_wr", 3'd2, U, 1'b0, M, 1'b1);
      issue("u_rd_068", 1'b0, 12'h068, U, 0, E_PRIV);

      // Unmapped and reserved-privilege cases; five denies saturate at 3.
      clear_cnt("c0");
      issue("m_05c", 1'b0, 12'h05C, M, 0, E_UNMAP);
      issue("m_066", 1'b0, 12'h066, M, 0, E_UNMAP);
      issue("m_080", 1'b0, 12'h080, M, 0, E_UNMAP);
      issue("m_07c", 1'b0, 12'h07C, M, 0, E_NONE);
      issue("r_060", 1'b0, 12'h060, R, 0, E_RSVD);
      issue("r_099", 1'b1, 12'h099, R, 0, E_RSVD);

      // Clear coinciding with a deny leaves the count at one.
      issue("clr_inc", 1'b0, 12'h064, U, 1, E_PRIV);

      // Config write during CHECK is not seen by that check.
      cfg_idx = 3'd3; cfg_min_priv = U; cfg_lock = 1'b0; cfg_priv = M;
      issue("u_06c_mid", 1'b0, 12'h06C, U, 2, E_PRIV);
      issue("u_06c_new", 1'b0, 12'h06C, U, 0, E_NONE);

      // Response back-pressure: outputs held, no new request accepted.
      rsp_ready = 1'b0;
      issue("stall", 1'b0, 12'h064, U, 0, E_PRIV);
      for (int i = 0; i < 5; i++) begin
         check("stall_vld", rsp_valid_o, 1);
         check("stall_err", rsp_err_o, E_PRIV);
         check("stall_exc", rsp_exc_o, 1);
         check("stall_rdy", req_ready_o, 0);
         @(negedge clk_i);
      end
      rsp_ready = 1'b1;
      @(negedge clk_i);
      check("unstall_vld", rsp_valid_o, 0);
      check("unstall_rdy", req_ready_o, 1);

      // Reset while in CHECK drops the request and restores the policy.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h064; req_priv = U;
      @(negedge clk_i);
      req_valid = 1'b0;
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("midrst_vld", rsp_valid_o, 0);
      check("midrst_rdy", req_ready_o, 0);
      check("midrst_cnt", viol_cnt_o, 0);
      rst_ni = 1'b1;
      exp_cnt = '0;
      @(negedge clk_i);
      issue("post_u_064", 1'b0, 12'h064, U, 0, E_PRIV);
      issue("post_m_080", 1'b1, 12'h080, M, 0, E_UNMAP);
`ifdef REG_ACCESS_GUARD_AUDIT_EN
      check("flt_vld",  fault_valid_o, 1);
      check("flt_addr", fault_addr_o, 12'h064);
      check("flt_priv", fault_priv_o, U);
      check("flt_wr",   fault_write_o, 0);
      fault_clr = 1'b1;
      @(negedge clk_i);
      fault_clr = 1'b0;
      check("flt_clr", fault_valid_o, 0);
`endif
      cfg_write("post_cfg2", 3'd2, U, 1'b0, M, 1'b0);
      issue("post_u_068", 1'b0, 12'h068, U, 0, E_NONE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit so a stuck design still ends with a summary.
   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout: got no end of test, expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
